jtframe_objscan: RTL
====================

JTFRAME_OBJSCAN -- requirements
Module: jtframe_objscan

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- AW, 7, object RAM word-address width; 4 words per object
- OBJN, 32, objects scanned per line; 1 to 2^(AW-2)
- CW, 12, code width; at most 16
- PW, 8, pixel width; pal width is PW-4
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, single clock
- rstn, in, 1, reset: synchronous, active-low
- hs, in, 1, horizontal sync; rising edge starts a scan
- vrender, in, 9, line being prepared
- ram_addr, out, AW, object RAM address
- ram_dout, in, 16, object RAM data, valid 1 clk after ram_addr
- draw, out, 1, draw request strobe to the drawer
- busy, in, 1, drawer busy
- code, out, CW, tile code
- xpos, out, 9, horizontal position
- ysub, out, 4, row within the 16-line object
- hflip, out, 1, horizontal flip
- vflip, out, 1, vertical flip
- pal, out, PW-4, palette
- done, out, 1, high when the scan for the current line is complete

Function
REQ-003 Object n SHALL occupy words 4n..4n+3:
- w0[15]: enable
- w0[8:0]: ypos
- w1[8:0]: xpos
- w2[CW-1:0]: code
- w3[0]: hflip
- w3[1]: vflip
- w3[PW-3:2]: pal
REQ-004 Vertical match:
- ydiff = (vrender - ypos) mod 512, 9-bit wrap.
- Hit when enable=1 and ydiff<16; ysub = ydiff[3:0].
REQ-005 FSM states SHALL be IDLE, RD0, CHK, RD1, RD2, RD3, WAIT, NEXT, DONE.
REQ-006 IDLE: on the hs rising edge (hs=1, previous hs=0), set obj index to 0, clear done, and go to RD0.
REQ-007 RD0: ram_addr = {idx,2'd0}; go to CHK next clk.
REQ-008 CHK: evaluate ram_dout as w0.
- Miss: go to NEXT.
- Hit: latch ysub, issue ram_addr for w1, go to RD1.
REQ-009 RD1, RD2 and RD3 SHALL each capture the returned word into a shadow register and advance the address.
- Fetch is pipelined; RD3 captures w3.
- Then go to WAIT.
REQ-010 WAIT: when busy=0 and draw=0, copy the shadow registers to the outputs, pulse draw for exactly 1 clk, and go to NEXT.
REQ-011 After draw, the block SHALL NOT issue another draw until busy has been sampled low at least 2 clks after the draw pulse, which covers the drawer's 1-clk busy rise latency.
REQ-012 Outputs code, xpos, ysub, hflip, vflip and pal SHALL stay unchanged while busy=1 or draw=1.
REQ-013 NEXT: if idx==OBJN-1, go to DONE; otherwise increment idx and go to RD0.
REQ-014 DONE: set done=1 and go to IDLE.
REQ-015 Throughput: a miss SHALL cost 3 clks; a hit with the drawer idle SHALL cost 6 clks to the draw pulse.
REQ-016 A hs rising edge in any non-IDLE state SHALL abort the scan, restart at idx 0 in RD0, and clear done.
- A pending unissued draw is dropped.
- Output registers are not modified while busy=1.
REQ-017 vrender SHALL be sampled at the hs rising edge and held for the whole scan.
REQ-018 idx width SHALL be AW-2; no wrap past OBJN-1.

Reset
REQ-019 While rstn=0 at a clk edge:
- state=IDLE, idx=0, draw=0, done=0, ram_addr=0
- code, xpos, ysub, hflip, vflip and pal = 0
- hs edge detector cleared, so hs held high during reset does not start a scan when rstn rises
REQ-020 Reset asserted mid-scan or mid-WAIT SHALL take effect on the next clk; no draw pulse follows.

Verification
REQ-021 Single hit:
- Stimulus: obj0 w0=0x8010, w1=0x050, w2=0x123, w3=0x0005; all other objects disabled; vrender=0x013; busy tied 0.
- Required: one draw pulse with code=0x123, xpos=0x050, ysub=3, hflip=1, vflip=0, pal=1; then done=1.
REQ-022 Wrap: ypos=0x1FA, vrender=0x004 -> hit with ysub=10. With vrender=0x00A -> no draw.
REQ-023 Backpressure:
- Stimulus: two hits; busy held high for 40 clks after the first draw.
- Required: the second draw occurs exactly 1 clk after busy falls, and outputs are stable throughout the busy window.
REQ-024 Abort: a hs rising edge during RD2 of obj5 -> ram_addr returns to 0 within 1 clk, no draw for obj5, and the scan restarts from obj0.
REQ-025 Miss timing: all OBJN=32 objects disabled -> done=1 at 32*3+1 clks after the hs edge, with no draw.
REQ-026 Reset: rstn low for 1 clk during WAIT -> draw=0, done=0, all outputs 0, and the next scan begins only on a fresh hs rising edge.

Source files
------------

// File: rtl/jtframe_objscan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtframe_objscan                                               |
// | Purpose  : Per-line sprite/object scanner. On each hs rising edge it     |
// |            walks the object table, tests every object against the line   |
// |            being prepared, fetches the attributes of visible objects and  |
// |            hands them one at a time to a drawer through a draw strobe.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk      in   1     single clock                                       |
// |   rstn     in   1     synchronous active-low reset                       |
// |   hs       in   1     horizontal sync, rising edge starts a scan         |
// |   vrender  in   9     line being prepared (latched at the hs edge)       |
// |   ram_addr out  AW    object RAM word address                            |
// |   ram_dout in   16    object RAM data, valid 1 clk after ram_addr        |
// |   draw     out  1     one-clock draw request to the drawer               |
// |   busy     in   1     drawer busy                                        |
// |   code     out  CW    tile code of the object being drawn                |
// |   xpos     out  9     horizontal position                                |
// |   ysub     out  4     row inside the 16-line object                      |
// |   hflip    out  1     horizontal flip                                    |
// |   vflip    out  1     vertical flip                                      |
// |   pal      out  PW-4  palette                                            |
// |   done     out  1     scan of the current line finished                  |
// | Object n uses words 4n..4n+3:                                            |
// |   w0[15] enable, w0[8:0] ypos, w1[8:0] xpos, w2[CW-1:0] code,            |
// |   w3[0] hflip, w3[1] vflip, w3[PW-3:2] pal                               |
// +--------------------------------------------------------------------------+
module jtframe_objscan #(
  parameter int AW   = 7,
  parameter int OBJN = 32,
  parameter int CW   = 12,
  parameter int PW   = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hs,
  input  logic [8:0]    vrender,
  output logic [AW-1:0] ram_addr,
  input  logic [15:0]   ram_dout,
  output logic          draw,
  input  logic          busy,
  output logic [CW-1:0] code,
  output logic [8:0]    xpos,
  output logic [3:0]    ysub,
  output logic          hflip,
  output logic          vflip,
  output logic [PW-5:0] pal,
  output logic          done
);

  localparam int              C_IW       = AW - 2;
  localparam logic [C_IW-1:0] C_LAST_IDX = C_IW'(OBJN - 1);
  localparam int              C_ATW      = PW - 2;   // hflip, vflip and pal

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD0  = 4'd1,
    CHK  = 4'd2,
    RD1  = 4'd3,
    RD2  = 4'd4,
    RD3  = 4'd5,
    WAIT = 4'd6,
    NEXT = 4'd7,
    DONE = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [C_IW-1:0]  idx_q, idx_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             hs_q;
  logic [8:0]       vr_q, vr_d;
  logic             draw_q, draw_d;
  logic             done_q, done_d;
  logic [1:0]       gap_q, gap_d;

  // Shadow registers filled during the fetch, presented only at draw time
  logic [3:0]       sh_ysub_q, sh_ysub_d;
  logic [8:0]       sh_xpos_q, sh_xpos_d;
  logic [CW-1:0]    sh_code_q, sh_code_d;
  logic [C_ATW-1:0] sh_attr_q, sh_attr_d;

  // Registers seen by the drawer
  logic [3:0]       ysub_q, ysub_d;
  logic [8:0]       xpos_q, xpos_d;
  logic [CW-1:0]    code_q, code_d;
  logic [C_ATW-1:0] attr_q, attr_d;

  logic             w_hs_rise;
  logic [8:0]       w_ydiff;
  logic             w_hit;
  logic             w_issue;
  logic             unused_dout;

  assign w_hs_rise = hs & ~hs_q;

  // 9-bit subtraction wraps naturally, so objects straddling line 511/0 match
  assign w_ydiff = vr_q - ram_dout[8:0];
  assign w_hit   = ram_dout[15] && (w_ydiff[8:4] == 5'd0);

  // A draw is handed over only when the drawer is free and the previous
  // strobe has had time to raise busy; an hs edge in the same clock wins.
  assign w_issue = (state_q == WAIT) && !busy && !draw_q &&
                   (gap_q == 2'd0) && !w_hs_rise;

  // Only some bits of each word carry fields
  assign unused_dout = ^ram_dout;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vr_d      = vr_q;
    draw_d    = 1'b0;
    done_d    = done_q;
    gap_d     = (gap_q != 2'd0) ? gap_q - 2'd1 : gap_q;
    sh_ysub_d = sh_ysub_q;
    sh_xpos_d = sh_xpos_q;
    sh_code_d = sh_code_q;
    sh_attr_d = sh_attr_q;
    ysub_d    = ysub_q;
    xpos_d    = xpos_q;
    code_d    = code_q;
    attr_d    = attr_q;
    addr_d    = addr_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RD0: begin
        state_d = CHK;
      end
      CHK: begin
        if (w_hit) begin
          sh_ysub_d = w_ydiff[3:0];
          state_d   = RD1;
        end else begin
          state_d   = NEXT;
        end
      end
      RD1: begin
        sh_xpos_d = ram_dout[8:0];
        state_d   = RD2;
      end
      RD2: begin
        sh_code_d = ram_dout[CW-1:0];
        state_d   = RD3;
      end
      RD3: begin
        sh_attr_d = ram_dout[C_ATW-1:0];
        state_d   = WAIT;
      end
      WAIT: begin
        if (w_issue) begin
          ysub_d  = sh_ysub_q;
          xpos_d  = sh_xpos_q;
          code_d  = sh_code_q;
          attr_d  = sh_attr_q;
          draw_d  = 1'b1;
          gap_d   = 2'd2;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == C_LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + C_IW'(1);
          state_d = RD0;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // hs edge starts a scan from IDLE or aborts one in flight
    if (w_hs_rise) begin
      state_d = RD0;
      idx_d   = '0;
      done_d  = 1'b0;
      vr_d    = vrender;
    end

    // The address always leads the state by one clock so the word needed
    // by the next state is already on ram_dout when that state runs.
    // CHK speculatively points at w1; a miss simply ignores it.
    case (state_d)
      RD0:     addr_d = {idx_d, 2'd0};
      CHK:     addr_d = {idx_d, 2'd1};
      RD1:     addr_d = {idx_d, 2'd2};
      RD2:     addr_d = {idx_d, 2'd3};
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      vr_q      <= '0;
      draw_q    <= 1'b0;
      done_q    <= 1'b0;
      gap_q     <= 2'd0;
      sh_ysub_q <= '0;
      sh_xpos_q <= '0;
      sh_code_q <= '0;
      sh_attr_q <= '0;
      ysub_q    <= '0;
      xpos_q    <= '0;
      code_q    <= '0;
      attr_q    <= '0;
      // Track the level so hs held high through reset is not seen as an edge
      hs_q      <= hs;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      vr_q      <= vr_d;
      draw_q    <= draw_d;
      done_q    <= done_d;
      gap_q     <= gap_d;
      sh_ysub_q <= sh_ysub_d;
      sh_xpos_q <= sh_xpos_d;
      sh_code_q <= sh_code_d;
      sh_attr_q <= sh_attr_d;
      ysub_q    <= ysub_d;
      xpos_q    <= xpos_d;
      code_q    <= code_d;
      attr_q    <= attr_d;
      hs_q      <= hs;
    end
  end

  assign ram_addr = addr_q;
  assign draw     = draw_q;
  assign done     = done_q;
  assign code     = code_q;
  assign xpos     = xpos_q;
  assign ysub     = ysub_q;
  assign hflip    = attr_q[0];
  assign vflip    = attr_q[1];
  assign pal      = attr_q[C_ATW-1:2];

endmodule
`default_nettype wire
